serial_tx_shifter: RTL
======================

Name: serial_tx_shifter

Overview:
Parallel-in/serial-out transmitter, the sending end of the 4-bit serial shift-register link. It latches a parallel word on request and shifts it out LSB first, one bit per clk_2 cycle. A bit strobe marks each bit, so a serial-in receiver clocking its MSB-in register on that strobe holds the original word after NBITS_DATA strobes. The word being sent is shown on the 7-segment display.

Parameters:
NBITS_DATA, 4, width of the transmitted word; legal range 2..8.

Ports:
clk_2  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
start  input  1  transmit request, level-sensitive, sampled only in IDLE.
data_in  input  NBITS_DATA  parallel word to send; sampled on the accepting edge.
data_serial  output  1  serial data bit, valid while shift_en=1.
shift_en  output  1  bit strobe; high exactly NBITS_DATA consecutive cycles per frame.
busy  output  1  high in SHIFT and DONE.
done  output  1  one-cycle pulse after the last bit.
tx_word  output  NBITS_DATA  copy of the last accepted word.
SEG  output  8  7-segment pattern of tx_word[3:0]; bit 7 (dp) always 0.

Behaviour:
- State register: IDLE, SHIFT, DONE. Also a shift register shreg[NBITS_DATA], a bit counter bit_cnt[$clog2(NBITS_DATA)] and tx_word.
- Reset (reset=0, asynchronous): state=IDLE, shreg=0, bit_cnt=0, tx_word=0. Outputs: data_serial=0, shift_en=0, busy=0, done=0, SEG=0x3F. Reset takes effect immediately, including mid-frame; the partial frame is dropped with no done pulse.
- IDLE: shift_en=0, busy=0, data_serial=0.
  - start=1 at an edge: shreg<=data_in, tx_word<=data_in, bit_cnt<=0, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT: shift_en=1, busy=1, data_serial=shreg[0]. These are decoded from state/registers, with no extra latency.
  - Each edge: shreg<=shreg>>1 (zero fill), bit_cnt<=bit_cnt+1.
  - When bit_cnt==NBITS_DATA-1 at an edge: go to DONE.
  - start and data_in are ignored throughout.
- DONE: done=1, busy=1, shift_en=0, data_serial=0. Go to IDLE on the next edge unconditionally; start is ignored.
- Latency:
  - start accepted at edge k.
  - Bit i (LSB = bit 0) is driven during the cycle after edge k+i, for i=0..NBITS_DATA-1.
  - done is high during the cycle after edge k+NBITS_DATA.
  - IDLE is entered at edge k+NBITS_DATA+1.
- Back-to-back: if start stays high, the next frame is accepted at the first edge in IDLE. The minimum frame period is NBITS_DATA+2 cycles, with a guaranteed one-cycle gap in shift_en between frames.
- SEG decode, combinational from tx_word[3:0], values in hex:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, B:7C, C:39, D:5E, E:79, F:71
  - For NBITS_DATA<4, upper bits are zero-extended.
- tx_word and SEG hold their value across IDLE/SHIFT/DONE and change only on acceptance or reset.
- No illegal-state lockup: an unencoded state value returns to IDLE on the next edge.

Test Plan:
1. Reset check: hold reset=0 for 3 cycles with start=1 and data_in=0xA -> all outputs 0, SEG=0x3F, busy never rises. Release reset with start=0 -> stays IDLE.
2. Single frame: data_in=4'b1011, start pulsed for 1 cycle -> shift_en high 4 cycles with data_serial=1,1,0,1, then done=1 for 1 cycle, busy high 5 cycles. tx_word=0xB, SEG=0x7C.
3. Input changes mid-frame: during SHIFT, change data_in to 0x0 and toggle start -> serial sequence and tx_word are unaffected, and no extra frame is started from the toggles.
4. Continuous start: start held 1 with data_in=0x3 -> frames repeat every 6 cycles, and shift_en is low for exactly 2 cycles between frames.
5. Reset mid-frame: assert reset=0 after bit 1 of data_in=0xF -> shift_en, busy and data_serial drop to 0 immediately, no done pulse, tx_word=0, SEG=0x3F.
6. Loopback sweep: connect a 4-bit MSB-in shift-register model clocked on shift_en, and send words 0x0 to 0xF -> the recovered word equals tx_word after every done, and SEG matches the table for each value.

Source files
------------

// File: rtl/serial_tx_shifter.sv
// ---------------------------------------------------------------------------
// serial_tx_shifter
//
// Parallel-in / serial-out transmitter. A parallel word is latched when a
// transmit request is seen in IDLE. It is then shifted out LSB first, one bit
// per clk_2 cycle, and each bit is marked with a strobe (shift_en). A receiver
// that clocks an MSB-in shift register on the strobe holds the original word
// after NBITS_DATA strobes. The last accepted word is also shown on a
// 7-segment display.
//
// Handshake: start is a level-sensitive request. It is sampled only while
// the FSM is in IDLE, and a rising clk_2 edge with start=1 in IDLE accepts
// data_in. Nothing is sampled in SHIFT or DONE, and no acknowledge is given
// beyond busy/done. A request that is held high therefore starts one frame
// every NBITS_DATA+2 cycles.
//
// Ports:
//   clk_2        in   system clock, rising edge
//   reset        in   asynchronous reset, active low
//   start        in   transmit request (level, sampled in IDLE only)
//   data_in      in   [NBITS_DATA] word to send, sampled on the accepting edge
//   data_serial  out  serial bit, valid while shift_en=1, otherwise 0
//   shift_en     out  bit strobe, NBITS_DATA consecutive cycles per frame
//   busy         out  high in SHIFT and DONE
//   done         out  one-cycle pulse after the last bit
//   tx_word      out  [NBITS_DATA] copy of the last accepted word
//   SEG          out  [8] 7-segment pattern of tx_word[3:0], dp (bit 7) = 0
// ---------------------------------------------------------------------------
module serial_tx_shifter #(
    parameter int NBITS_DATA = 4
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NBITS_DATA-1:0] data_in,
    output logic                  data_serial,
    output logic                  shift_en,
    output logic                  busy,
    output logic                  done,
    output logic [NBITS_DATA-1:0] tx_word,
    output logic [7:0]            SEG
);

    localparam int CNT_W = (NBITS_DATA > 1) ? $clog2(NBITS_DATA) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS_DATA - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [NBITS_DATA-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [3:0]            seg_nib;

    // -----------------------------------------------------------------------
    // Control FSM and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx_word <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= data_in;
                        tx_word <= data_in;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // shreg[0] is on the line during this cycle. The shift
                    // brings the next bit down for the following cycle.
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // DONE always spends one cycle here. This gives the
                    // guaranteed gap in shift_en between back-to-back frames.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs are decoded from registered state only. They have no input
    // paths and add no latency.
    // -----------------------------------------------------------------------
    assign shift_en    = (state == SHIFT);
    assign done        = (state == DONE);
    assign busy        = (state == SHIFT) || (state == DONE);
    assign data_serial = (state == SHIFT) && shreg[0];

    // Narrow words are zero-extended so the display still shows the value.
    if (NBITS_DATA >= 4) begin : g_nib_wide
        assign seg_nib = tx_word[3:0];
    end else begin : g_nib_narrow
        assign seg_nib = {{(4 - NBITS_DATA){1'b0}}, tx_word};
    end

    // Segment order is {dp, g, f, e, d, c, b, a}. dp is never lit.
    always_comb begin
        SEG = 8'h00;
        case (seg_nib)
            4'h0: SEG = 8'h3F;
            4'h1: SEG = 8'h06;
            4'h2: SEG = 8'h5B;
            4'h3: SEG = 8'h4F;
            4'h4: SEG = 8'h66;
            4'h5: SEG = 8'h6D;
            4'h6: SEG = 8'h7D;
            4'h7: SEG = 8'h07;
            4'h8: SEG = 8'h7F;
            4'h9: SEG = 8'h6F;
            4'hA: SEG = 8'h77;
            4'hB: SEG = 8'h7C;
            4'hC: SEG = 8'h39;
            4'hD: SEG = 8'h5E;
            4'hE: SEG = 8'h79;
            4'hF: SEG = 8'h71;
            default: SEG = 8'h00;
        endcase
    end

endmodule
